// File: rtl/mmu_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mmu_sram_responder_if
// Description : MMU shared-bus signal bundle between the arbiter (master)
//               and a subordinate responder (slave).
//               master drives : SELX, ADDR, WRITE_DATA, WRITE, SIZE, BURST, TRANS
//               slave drives  : READ_DATA, READYOUT, RESP
// Revision    : 1.0 - initial release
// ============================================================================
interface mmu_sram_responder_if;
    logic        SELX;
    logic [31:0] ADDR;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        WRITE;
    logic [2:0]  SIZE;
    logic [2:0]  BURST;
    logic [2:0]  TRANS;
    logic        READYOUT;
    logic        RESP;

    modport master (
        output SELX, ADDR, WRITE_DATA, WRITE, SIZE, BURST, TRANS,
        input  READ_DATA, READYOUT, RESP
    );

    modport slave (
        input  SELX, ADDR, WRITE_DATA, WRITE, SIZE, BURST, TRANS,
        output READ_DATA, READYOUT, RESP
    );
endinterface
`default_nettype wire

// File: rtl/mmu_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmu_sram_responder
// Description : MMU shared-bus subordinate backed by a local word-organised
//               SRAM covering byte addresses [0, ADDR_LIMIT). Handles SINGLE
//               and INCR4/8/16 bursts of byte/half/word beats, reporting
//               malformed or out-of-window beats through RESP. All outputs
//               are registered (one-cycle response latency).
// Ports       : CLK   - clock
//               RSTN  - synchronous active-low reset
//               bus   - slave side of the MMU bus bundle
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_sram_responder #(
    parameter int          MEM_WORDS  = 64,
    parameter logic [31:0] ADDR_LIMIT = 32'h100
) (
    input wire                  CLK,
    input wire                  RSTN,
    mmu_sram_responder_if.slave bus
);

    localparam int         IDX_W        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0] TRANS_NONSEQ = 3'd2;
    localparam logic [2:0] TRANS_SEQ    = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Beat width in bytes; widened to 33 bits so window checks cannot wrap.
    function automatic logic [32:0] beat_bytes(input logic [2:0] size);
        case (size)
            3'd0:    return 33'd1;
            3'd1:    return 33'd2;
            default: return 33'd4;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state, state_nxt;
    logic        readyout, readyout_nxt;
    logic        resp, resp_nxt;
    logic [31:0] read_data, read_data_nxt;
    logic [31:0] next_addr, next_addr_nxt;
    logic [4:0]  depth, depth_nxt;
    logic [4:0]  total, total_nxt;
    logic        write_q, write_q_nxt;
    logic [2:0]  size_q, size_q_nxt;

    logic [31:0] mem [MEM_WORDS];

    // Access selected for this cycle (start beat or continuation beat)
    logic        acc_en;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [2:0]  acc_size;
    logic        do_start;

    // ------------------------------------------------------------------
    // Start-of-transfer decode (uses the live bus)
    // ------------------------------------------------------------------
    logic [32:0] start_bytes;
    logic        start_ok;
    logic [4:0]  start_total;

    assign start_bytes = beat_bytes(bus.SIZE);
    assign start_ok    = (bus.SIZE <= 3'd2)
                      && (bus.BURST <= 3'd3)
                      && ((bus.ADDR & (start_bytes[31:0] - 32'd1)) == 32'd0)
                      && (({1'b0, bus.ADDR} + start_bytes) <= {1'b0, ADDR_LIMIT});

    always_comb begin
        case (bus.BURST)
            3'd1:    start_total = 5'd4;
            3'd2:    start_total = 5'd8;
            3'd3:    start_total = 5'd16;
            default: start_total = 5'd1;
        endcase
    end

    // Continuation beats use the address counter and the latched size;
    // a beat that would run past the window aborts the burst instead of
    // wrapping.
    logic [32:0] seq_bytes;
    logic        seq_ok;

    assign seq_bytes = beat_bytes(size_q);
    assign seq_ok    = ({1'b0, next_addr} + seq_bytes) <= {1'b0, ADDR_LIMIT};

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        readyout_nxt  = 1'b1;
        resp_nxt      = 1'b0;
        next_addr_nxt = next_addr;
        depth_nxt     = depth;
        total_nxt     = total;
        write_q_nxt   = write_q;
        size_q_nxt    = size_q;
        acc_en        = 1'b0;
        acc_write     = write_q;
        acc_addr      = next_addr;
        acc_size      = size_q;
        do_start      = 1'b0;

        case (state)
            ST_IDLE: begin
                do_start = (bus.TRANS == TRANS_NONSEQ) && bus.SELX;
            end

            ST_BURST: begin
                if (bus.TRANS == TRANS_SEQ) begin
                    if (!seq_ok) begin
                        state_nxt = ST_ERR;
                        resp_nxt  = 1'b1;
                    end else begin
                        acc_en        = 1'b1;
                        next_addr_nxt = next_addr + seq_bytes[31:0];
                        depth_nxt     = depth + 5'd1;
                        if (depth + 5'd1 == total) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            readyout_nxt = 1'b0;
                        end
                    end
                end else if ((bus.TRANS == TRANS_NONSEQ) && bus.SELX) begin
                    // New transfer abandons the burst in flight
                    do_start = 1'b1;
                end else begin
                    // IDLE, reserved encodings, or NONSEQ to another target
                    state_nxt = ST_IDLE;
                end
            end

            ST_ERR: begin
                // Error response lasts one cycle; bus inputs are ignored here
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (do_start) begin
            write_q_nxt = bus.WRITE;
            size_q_nxt  = bus.SIZE;
            total_nxt   = start_total;
            if (!start_ok) begin
                state_nxt = ST_ERR;
                resp_nxt  = 1'b1;
            end else begin
                acc_en        = 1'b1;
                acc_write     = bus.WRITE;
                acc_addr      = bus.ADDR;
                acc_size      = bus.SIZE;
                next_addr_nxt = bus.ADDR + start_bytes[31:0];
                depth_nxt     = 5'd1;
                if (start_total == 5'd1) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt    = ST_BURST;
                    readyout_nxt = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory datapath
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [3:0]       wr_be;
    logic [31:0]      wr_lane;
    logic             unused_addr_bits;

    assign acc_idx          = acc_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{acc_addr[31:IDX_W+2]};
    assign rd_word          = mem[acc_idx];
    assign rd_shift         = rd_word >> {acc_addr[1:0], 3'b000};

    // Read beats: addressed bytes moved down to bit 0, zero-extended.
    // Write beats leave READ_DATA untouched.
    always_comb begin
        read_data_nxt = read_data;
        if (acc_en && !acc_write) begin
            case (acc_size)
                3'd0:    read_data_nxt = {24'd0, rd_shift[7:0]};
                3'd1:    read_data_nxt = {16'd0, rd_shift[15:0]};
                default: read_data_nxt = rd_word;
            endcase
        end
    end

    // Write data is LSB-justified on the bus; replicate it across the lanes
    // so the byte enables alone pick the destination bytes.
    always_comb begin
        case (acc_size)
            3'd0: begin
                wr_be   = 4'b0001 << acc_addr[1:0];
                wr_lane = {4{bus.WRITE_DATA[7:0]}};
            end
            3'd1: begin
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{bus.WRITE_DATA[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_lane = bus.WRITE_DATA;
            end
        endcase
    end

    // Storage is not reset; writes are suppressed while reset is asserted so
    // a reset mid-burst drops the pending beat.
    always_ff @(posedge CLK) begin
        if (RSTN && acc_en && acc_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            readyout  <= 1'b1;
            resp      <= 1'b0;
            read_data <= 32'd0;
            next_addr <= 32'd0;
            depth     <= 5'd0;
            total     <= 5'd1;
            write_q   <= 1'b0;
            size_q    <= 3'd0;
        end else begin
            state     <= state_nxt;
            readyout  <= readyout_nxt;
            resp      <= resp_nxt;
            read_data <= read_data_nxt;
            next_addr <= next_addr_nxt;
            depth     <= depth_nxt;
            total     <= total_nxt;
            write_q   <= write_q_nxt;
            size_q    <= size_q_nxt;
        end
    end

    assign bus.READ_DATA = read_data;
    assign bus.READYOUT  = readyout;
    assign bus.RESP      = resp;

endmodule
`default_nettype wire

// File: tb/tb_mmu_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_sram_responder
// Description : Self-checking bench for mmu_sram_responder. A byte-array
//               reference memory and a per-transfer beat model predict the
//               READYOUT/RESP/READ_DATA seen after every bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_sram_responder;

    localparam longint LIMIT = 64'h100;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;

    always #5 CLK = ~CLK;

    mmu_sram_responder_if bus ();

    mmu_sram_responder #(
        .MEM_WORDS (64),
        .ADDR_LIMIT(32'h100)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [256];
    logic [31:0] wd_tab  [16];
    logic [31:0] last_rd = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit rdy, input bit rsp, input logic [31:0] rd);
        chk($sformatf("%s.READYOUT", tag), {31'd0, bus.READYOUT}, {31'd0, rdy});
        chk($sformatf("%s.RESP", tag),     {31'd0, bus.RESP},     {31'd0, rsp});
        chk($sformatf("%s.READ_DATA", tag), bus.READ_DATA, rd);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) wd_tab[i] = $urandom;
    endtask

    task automatic idle_step(input string tag);
        bus.SELX  = 1'b0;
        bus.TRANS = 3'($urandom_range(0, 3));
        bus.ADDR  = $urandom;
        step();
        expect_out(tag, 1'b1, 1'b0, last_rd);
    endtask

    // One transfer: beat i of a burst touches addr + i*bytes. An illegal
    // start or a beat leaving the window gives one error cycle and no access.
    // abort_at / rst_at: beat index replaced by TRANS=IDLE / by a reset.
    task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [2:0] burst,
                        input int abort_at, input int rst_at);
        int     nbeats;
        longint bytes;
        longint a;
        bit     ok;
        logic [31:0] exp_rd;
        case (burst)
            3'd0: nbeats = 1;
            3'd1: nbeats = 4;
            3'd2: nbeats = 8;
            3'd3: nbeats = 16;
            default: nbeats = 1;
        endcase
        bytes = longint'(1) << size;
        ok = (size <= 3'd2) && (burst <= 3'd3) && ((longint'(addr) % bytes) == 0)
             && (longint'(addr) + bytes <= LIMIT);
        for (int i = 0; i < nbeats; i++) begin
            a = longint'(addr) + longint'(i) * bytes;
            if (i == rst_at) begin
                RSTN      = 1'b0;
                bus.SELX  = 1'b1;
                bus.TRANS = 3'd3;
                bus.WRITE_DATA = $urandom;
                step();
                last_rd = 32'd0;
                expect_out({tag, ".reset"}, 1'b1, 1'b0, 32'd0);
                RSTN = 1'b1;
                return;
            end
            if (i == abort_at) begin
                bus.TRANS = 3'd0;
                step();
                expect_out({tag, ".abort"}, 1'b1, 1'b0, last_rd);
                return;
            end
            bus.SELX       = 1'b1;
            bus.TRANS      = (i == 0) ? 3'd2 : 3'd3;
            bus.ADDR       = (i == 0) ? addr : $urandom;
            bus.WRITE      = (i == 0) ? wr : 1'($urandom);
            bus.SIZE       = (i == 0) ? size : 3'($urandom);
            bus.BURST      = burst;
            bus.WRITE_DATA = wd_tab[i];
            step();
            if ((i == 0 && !ok) || (i > 0 && a + bytes > LIMIT)) begin
                expect_out($sformatf("%s.err%0d", tag, i), 1'b1, 1'b1, last_rd);
                // Inputs during the error cycle must be ignored
                bus.SELX       = 1'b1;
                bus.TRANS      = 3'd2;
                bus.WRITE      = 1'b1;
                bus.ADDR       = 32'h0;
                bus.SIZE       = 3'd2;
                bus.BURST      = 3'd0;
                bus.WRITE_DATA = $urandom;
                step();
                expect_out({tag, ".after_err"}, 1'b1, 1'b0, last_rd);
                return;
            end
            if (wr) begin
                for (int k = 0; k < int'(bytes); k++)
                    ref_mem[int'(a) + k] = wd_tab[i][8*k +: 8];
            end else begin
                exp_rd = 32'd0;
                for (int k = 0; k < int'(bytes); k++)
                    exp_rd[8*k +: 8] = ref_mem[int'(a) + k];
                last_rd = exp_rd;
            end
            expect_out($sformatf("%s.beat%0d", tag, i), (i == nbeats - 1), 1'b0, last_rd);
        end
    endtask

    initial begin
        bus.SELX = 1'b0; bus.ADDR = 32'h0; bus.WRITE_DATA = 32'h0; bus.WRITE = 1'b0;
        bus.SIZE = 3'd0; bus.BURST = 3'd0; bus.TRANS = 3'd0;

        RSTN = 1'b0;
        step();
        step();
        expect_out("reset", 1'b1, 1'b0, 32'd0);
        RSTN = 1'b1;
        idle_step("idle0");

        // Give the whole memory known contents
        for (int b = 0; b < 4; b++) begin
            fill_random();
            xfer("fill", 1'b1, 32'(b * 64), 3'd2, 3'd3, -1, -1);
        end

        // Single word
        wd_tab[0] = 32'hDEADBEEF;
        xfer("single_wr", 1'b1, 32'h10, 3'd2, 3'd0, -1, -1);
        xfer("single_rd", 1'b0, 32'h10, 3'd2, 3'd0, -1, -1);
        chk("single_const", bus.READ_DATA, 32'hDEADBEEF);

        // INCR4 write then read back
        for (int i = 0; i < 4; i++) wd_tab[i] = 32'(i + 1);
        xfer("incr4_wr", 1'b1, 32'h20, 3'd2, 3'd1, -1, -1);
        fill_random();
        xfer("incr4_rd", 1'b0, 32'h20, 3'd2, 3'd1, -1, -1);
        chk("incr4_last_const", bus.READ_DATA, 32'd4);

        // Byte merge
        wd_tab[0] = 32'h11223344;
        xfer("merge_wr", 1'b1, 32'h30, 3'd2, 3'd0, -1, -1);
        wd_tab[0] = 32'hFFFFFFAA;
        xfer("merge_byte", 1'b1, 32'h32, 3'd0, 3'd0, -1, -1);
        xfer("merge_rd", 1'b0, 32'h30, 3'd2, 3'd0, -1, -1);
        chk("merge_word_const", bus.READ_DATA, 32'h11AA3344);
        xfer("merge_half", 1'b0, 32'h32, 3'd1, 3'd0, -1, -1);
        chk("merge_half_const", bus.READ_DATA, 32'h000011AA);

        // Error responses, memory must not change
        fill_random();
        xfer("err_align", 1'b1, 32'h41, 3'd1, 3'd0, -1, -1);
        xfer("err_burst", 1'b1, 32'h40, 3'd2, 3'd5, -1, -1);
        xfer("err_size", 1'b1, 32'h40, 3'd3, 3'd0, -1, -1);
        xfer("err_chk", 1'b0, 32'h40, 3'd2, 3'd1, -1, -1);

        // Window boundary crossing mid-burst
        fill_random();
        xfer("bound_wr", 1'b1, 32'hF8, 3'd2, 3'd1, -1, -1);
        xfer("bound_rd0", 1'b0, 32'hF8, 3'd2, 3'd0, -1, -1);
        xfer("bound_rd1", 1'b0, 32'hFC, 3'd2, 3'd0, -1, -1);
        xfer("bound_start", 1'b0, 32'h100, 3'd0, 3'd0, -1, -1);

        // Aborts
        xfer("abort_idle", 1'b0, 32'h00, 3'd2, 3'd2, 3, -1);
        fill_random();
        xfer("abort_rst", 1'b1, 32'h40, 3'd2, 3'd2, -1, 3);
        xfer("abort_rst_chk", 1'b0, 32'h40, 3'd2, 3'd2, -1, -1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  sz;
            logic [2:0]  bu;
            logic [31:0] ad;
            int          ab;
            sz = 3'($urandom_range(0, 3));
            bu = 3'($urandom_range(0, 5));
            ad = 32'($urandom_range(0, 32'h10F));
            if ($urandom_range(0, 7) != 0 && sz <= 3'd2)
                ad = ad & ~((32'd1 << sz) - 32'd1);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : -1;
            fill_random();
            xfer($sformatf("rnd%0d", n), 1'($urandom), ad, sz, bu, ab, -1);
            if ($urandom_range(0, 3) == 0) idle_step($sformatf("rnd_idle%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
